// File: rtl/mux_tree_pkg.sv
// Shared definitions for the flow-controlled bit-select pipeline:
// final-stage mode encodings and the select-width helper.
package mux_tree_pkg;

    typedef enum logic [1:0] {
        MODE_LEGACY = 2'b00,
        MODE_DIRECT = 2'b01,
        MODE_XOR    = 2'b10,
        MODE_AND    = 2'b11
    } mode_e;

    // Select width needed to address every bit of a DW-bit word.
    function automatic int unsigned sel_width(input int unsigned dw);
        return $clog2(dw);
    endfunction

endpackage

// File: rtl/mux_nto1.sv
// DW:1 bit selector; picks data[sel]. Purely combinational.
module mux_nto1
    import mux_tree_pkg::*;
#(
    parameter  int unsigned DW = 8,
    localparam int unsigned SW = sel_width(DW)
) (
    input  logic [DW-1:0] data,
    input  logic [SW-1:0] sel,
    output logic          sel_bit_c
);

    assign sel_bit_c = data[sel];

endmodule

// File: rtl/mux_tree_pipe.sv
// Two-stage valid/ready pipeline: captures A, B, C and mode, selects one bit of
// A and of C, combines them by mode and keeps a saturating count of delivered ones.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter  int unsigned DW    = 8,
    parameter  int unsigned CNT_W = 16,
    localparam int unsigned SW    = sel_width(DW)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    a_in,
    input  logic [2*SW-1:0]  b_in,
    input  logic [DW-1:0]    c_in,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y_out,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ones_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic          s1_valid;
    logic [DW-1:0] s1_a;
    logic [DW-1:0] s1_c;
    logic [SW-1:0] s1_sel_a;
    logic [SW-1:0] s1_sel_c;
    mode_e         s1_mode;

    logic          s2_load;
    logic          in_fire;
    logic          out_fire;
    logic          bit_a;
    logic          bit_c;
    logic [3:0]    v;
    logic [1:0]    leg_idx;
    logic          y_next;

    // S2 frees up when empty or being drained; S1 then advances into it.
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_a     <= '0;
            s1_c     <= '0;
            s1_sel_a <= '0;
            s1_sel_c <= '0;
            s1_mode  <= MODE_LEGACY;
        end else if (in_fire) begin
            s1_a     <= a_in;
            s1_c     <= c_in;
            s1_sel_a <= b_in[SW-1:0];
            s1_sel_c <= b_in[2*SW-1:SW];
            s1_mode  <= mode_e'(mode);
        end
    end

    mux_nto1 #(.DW(DW)) u_mux_a (
        .data      (s1_a),
        .sel       (s1_sel_a),
        .sel_bit_c (bit_a)
    );

    mux_nto1 #(.DW(DW)) u_mux_c (
        .data      (s1_c),
        .sel       (s1_sel_c),
        .sel_bit_c (bit_c)
    );

    // Final stage; LEGACY reproduces the original 4:1 tree with inverted low select bits.
    always_comb begin
        v       = {1'b1, 1'b0, bit_c, bit_a};
        leg_idx = ~s1_sel_a[1:0];
        y_next  = 1'b0;
        case (s1_mode)
            MODE_LEGACY: y_next = v[leg_idx];
            MODE_DIRECT: y_next = v[s1_sel_a[1:0]];
            MODE_XOR:    y_next = bit_a ^ bit_c;
            MODE_AND:    y_next = bit_a & bit_c;
            default:     y_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            y_out     <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y_out <= y_next;
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ones_cnt <= '0;
        end else if (cnt_clr) begin
            ones_cnt <= '0;
        end else if (out_fire && y_out && (ones_cnt != CNT_MAX)) begin
            ones_cnt <= ones_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed and randomised checks of mux_tree_pipe at DW=4/CNT_W=2 and DW=8/CNT_W=16.
module tb_mux_tree_pipe;
    import mux_tree_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, y4, clr4;
    logic [3:0] a4, b4, c4;
    logic [1:0] mode4, cnt4;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, y8, clr8;
    logic [7:0]  a8, c8;
    logic [5:0]  b8;
    logic [1:0]  mode8;
    logic [15:0] cnt8;

    mux_tree_pipe #(.DW(4), .CNT_W(2)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .a_in(a4), .b_in(b4), .c_in(c4), .mode(mode4),
        .out_valid(out_valid4), .out_ready(out_ready4), .y_out(y4),
        .cnt_clr(clr4), .ones_cnt(cnt4)
    );

    mux_tree_pipe #(.DW(8), .CNT_W(16)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a_in(a8), .b_in(b8), .c_in(c8), .mode(mode8),
        .out_valid(out_valid8), .out_ready(out_ready8), .y_out(y8),
        .cnt_clr(clr8), .ones_cnt(cnt8)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_q[$];
    int   n_rx = 0;
    int   ones_model = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_y(input logic [7:0] a, input logic [5:0] b,
                                     input logic [7:0] c, input logic [1:0] m);
        int sa, sc, k;
        logic ba, bc;
        logic [3:0] v;
        sa = int'(b[2:0]);
        sc = int'(b[5:3]);
        ba = a[sa];
        bc = c[sc];
        v  = {1'b1, 1'b0, bc, ba};
        k  = sa % 4;
        case (m)
            2'b00:   return v[3 - k];
            2'b01:   return v[k];
            2'b10:   return ba ^ bc;
            default: return ba & bc;
        endcase
    endfunction

    task automatic step4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [1:0] m, input logic ordy, input logic clr);
        @(negedge clk);
        in_valid4 = v; a4 = a; b4 = b; c4 = c; mode4 = m; out_ready4 = ordy; clr4 = clr;
        #1;
    endtask

    // One DW=4 word through an empty pipe; idle cycles carry inverted data to expose live sampling.
    task automatic directed4(input string tag, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [1:0] m, input logic exp);
        step4(1'b1, a, b, c, m, 1'b1, 1'b0);
        check_eq({tag, "_rdy"}, 32'(in_ready4), 32'd1);
        step4(1'b0, ~a, ~b, ~c, ~m, 1'b1, 1'b0);
        check_eq({tag, "_lat"}, 32'(out_valid4), 32'd0);
        step4(1'b0, ~a, ~b, ~c, ~m, 1'b1, 1'b0);
        check_eq({tag, "_vld"}, 32'(out_valid4), 32'd1);
        check_eq({tag, "_y"}, 32'(y4), 32'(exp));
    endtask

    // DW=8 cycle with scoreboard: outputs are popped against exp_q on each out handshake.
    task automatic cycle8(input logic v, input logic [7:0] a, input logic [5:0] b, input logic [7:0] c,
                          input logic [1:0] m, input logic ordy, output logic took);
        logic e;
        @(negedge clk);
        in_valid8 = v; a8 = a; b8 = b; c8 = c; mode8 = m; out_ready8 = ordy;
        #1;
        took = v && in_ready8;
        if (out_valid8 && out_ready8) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_y", 32'(y8), 32'(e));
                if (e) ones_model++;
            end
            n_rx++;
        end
    endtask

    task automatic directed8(input string tag, input logic [7:0] a, input logic [5:0] b,
                             input logic [7:0] c, input logic [1:0] m, input logic exp);
        logic took;
        cycle8(1'b1, a, b, c, m, 1'b1, took);
        check_eq({tag, "_acc"}, 32'(took), 32'd1);
        exp_q.push_back(exp);
        cycle8(1'b0, ~a, ~b, ~c, ~m, 1'b1, took);
        check_eq({tag, "_lat"}, 32'(out_valid8), 32'd0);
        cycle8(1'b0, ~a, ~b, ~c, ~m, 1'b1, took);
        check_eq({tag, "_vld"}, 32'(out_valid8), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       took;
        logic       held_y;
        logic       held_ok;
        logic [5:0] t4_bits;
        logic       bitv;
        logic       cur_v;
        logic [7:0] ra, rc;
        logic [5:0] rb;
        logic [1:0] rm;
        int         sent;
        int         cyc;

        reset = 1'b0;
        in_valid4 = 0; a4 = 0; b4 = 0; c4 = 0; mode4 = 0; out_ready4 = 0; clr4 = 0;
        in_valid8 = 0; a8 = 0; b8 = 0; c8 = 0; mode8 = 0; out_ready8 = 0; clr8 = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rst_ovalid8", 32'(out_valid8), 32'd0);
        check_eq("rst_y8", 32'(y8), 32'd0);
        check_eq("rst_cnt8", 32'(cnt8), 32'd0);
        check_eq("rst_irdy8", 32'(in_ready8), 32'd1);
        check_eq("rst_ovalid4", 32'(out_valid4), 32'd0);

        // T1: reset with two words in flight, one already counted
        step4(1'b1, 4'hF, 4'h3, 4'hF, 2'b01, 1'b1, 1'b0);
        step4(1'b1, 4'hF, 4'h3, 4'hF, 2'b01, 1'b1, 1'b0);
        step4(1'b1, 4'hF, 4'h3, 4'hF, 2'b01, 1'b1, 1'b0);
        step4(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
        check_eq("t1_inflight_vld", 32'(out_valid4), 32'd1);
        check_eq("t1_inflight_cnt", 32'(cnt4), 32'd1);
        check_eq("t1_inflight_irdy", 32'(in_ready4), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("t1_rst_vld", 32'(out_valid4), 32'd0);
        check_eq("t1_rst_cnt", 32'(cnt4), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("t1_rel_irdy", 32'(in_ready4), 32'd1);
        step4(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0);
        check_eq("t1_noreplay0", 32'(out_valid4), 32'd0);
        step4(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0);
        check_eq("t1_noreplay1", 32'(out_valid4), 32'd0);
        check_eq("t1_cnt_after", 32'(cnt4), 32'd0);

        // T2: legacy sweep on DW=4
        directed4("t2_b0000", 4'b1000, 4'b0000, 4'b0100, 2'b00, 1'b1);
        directed4("t2_b0011", 4'b1000, 4'b0011, 4'b0100, 2'b00, 1'b1);
        directed4("t2_b0001", 4'b1000, 4'b0001, 4'b0100, 2'b00, 1'b0);
        directed4("t2_b1010", 4'b1000, 4'b1010, 4'b0100, 2'b00, 1'b1);
        step4(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0);
        check_eq("t2_cnt", 32'(cnt4), 32'd3);

        // T5: saturation at 3 and clear priority on DW=4 / CNT_W=2
        step4(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b1);
        step4(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0);
        check_eq("t5_clr", 32'(cnt4), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step4(1'b1, 4'hF, 4'h0, 4'hF, 2'b11, 1'b1, 1'b0);
            if (i == 4) check_eq("t5_cnt2", 32'(cnt4), 32'd2);
        end
        repeat (3) step4(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0);
        check_eq("t5_sat", 32'(cnt4), 32'd3);
        step4(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b1);
        step4(1'b1, 4'hF, 4'h0, 4'hF, 2'b11, 1'b1, 1'b0);
        check_eq("t5_clr2", 32'(cnt4), 32'd0);
        step4(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0);
        step4(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b1);
        check_eq("t5_clr_hs_vld", 32'(out_valid4), 32'd1);
        step4(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0);
        check_eq("t5_clr_prio", 32'(cnt4), 32'd0);
        step4(1'b1, 4'hF, 4'h0, 4'hF, 2'b11, 1'b1, 1'b0);
        repeat (3) step4(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0);
        check_eq("t5_inc", 32'(cnt4), 32'd1);

        // T3: mode coverage on DW=8; b = {sel_c, sel_a}
        directed8("t3_xor",    8'h80, {3'd0, 3'd7}, 8'h01, MODE_XOR,    1'b0);
        directed8("t3_and",    8'h80, {3'd0, 3'd7}, 8'h01, MODE_AND,    1'b1);
        directed8("t3_dir0",   8'h01, {3'd0, 3'd0}, 8'h00, MODE_DIRECT, 1'b1);
        directed8("t3_dir2",   8'h01, {3'd0, 3'd2}, 8'h00, MODE_DIRECT, 1'b0);
        directed8("t3_dir3",   8'h00, {3'd0, 3'd3}, 8'h00, MODE_DIRECT, 1'b1);
        directed8("t3_leg5",   8'hFF, {3'd0, 3'd5}, 8'h00, MODE_LEGACY, 1'b0);
        directed8("t3_leg6",   8'h00, {3'd0, 3'd6}, 8'h01, MODE_LEGACY, 1'b1);
        directed8("t3_leg7",   8'h00, {3'd0, 3'd7}, 8'hFF, MODE_LEGACY, 1'b0);

        // T4: six words, out_ready low for the first four cycles
        t4_bits = 6'b011010;
        sent = 0; cyc = 0; n_rx = 0; held_ok = 1'b0; held_y = 1'b0;
        while ((sent < 6 || exp_q.size() > 0) && cyc < 100) begin
            bitv = (sent < 6) ? t4_bits[sent] : 1'b0;
            cycle8(sent < 6, {4'hA, 3'(sent), bitv}, 6'd0, 8'h00, MODE_XOR, cyc >= 4, took);
            if (cyc == 2 || cyc == 3) begin
                check_eq("t4_irdy_low", 32'(in_ready8), 32'd0);
                check_eq("t4_acc_cnt", 32'(sent), 32'd2);
            end
            if (out_valid8 && !out_ready8) begin
                if (held_ok) check_eq("t4_hold", 32'(y8), 32'(held_y));
                held_y  = y8;
                held_ok = 1'b1;
            end
            if (took) begin
                exp_q.push_back(bitv);
                sent++;
            end
            cyc++;
        end
        check_eq("t4_drained", 32'(exp_q.size()), 32'd0);
        check_eq("t4_rx", 32'(n_rx), 32'd6);
        cycle8(1'b0, 8'h00, 6'd0, 8'h00, 2'b00, 1'b1, took);
        check_eq("t4_cnt", 32'(cnt8), 32'(ones_model));

        @(negedge clk);
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        #1;
        check_eq("t6_clr", 32'(cnt8), 32'd0);
        ones_model = 0;

        // T6: random valid/ready traffic, 10k words against the model
        sent = 0; cyc = 0; n_rx = 0; cur_v = 1'b0;
        ra = 0; rb = 0; rc = 0; rm = 0;
        while ((sent < 10000 || exp_q.size() > 0) && cyc < 60000) begin
            if (!cur_v && sent < 10000 && $urandom_range(3) != 0) begin
                cur_v = 1'b1;
                ra = 8'($urandom);
                rb = 6'($urandom);
                rc = 8'($urandom);
                rm = 2'($urandom);
            end
            cycle8(cur_v, ra, rb, rc, rm, $urandom_range(3) != 0, took);
            if (took) begin
                exp_q.push_back(model_y(ra, rb, rc, rm));
                sent++;
                cur_v = 1'b0;
            end
            cyc++;
        end
        check_eq("t6_rx", 32'(n_rx), 32'd10000);
        check_eq("t6_drained", 32'(exp_q.size()), 32'd0);
        cycle8(1'b0, 8'h00, 6'd0, 8'h00, 2'b00, 1'b1, took);
        check_eq("t6_cnt", 32'(cnt8), 32'(ones_model));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
